// File: rtl/rom_sequencer.sv
// rom_sequencer: byte-code sequencer that fetches opcodes from a 1-cycle-latency ROM, runs a 4-register ISA and streams bytes over valid/ready.
//   clk, reset (sync, active-high), start (restart pulse)
//   rom_addr -> ROM address (= ptr), rom_data <- ROM byte for the address sampled at the previous edge
//   tx_data/tx_valid/tx_ready: output byte stream
//   busy (not IDLE/ERR), done (pulse on HALT), error (sticky until start/reset), err_code (1 bad opcode, 2 overflow, 3 underflow)
module rom_sequencer #(
  parameter int AW          = 9,
  parameter int STACK_DEPTH = 4,
  parameter int LD_PAGE     = 1,
  parameter int START_ADDR  = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
  localparam logic [AW-1:0] START = AW'(START_ADDR);
  localparam logic [AW-9:0] PAGE = (AW-8)'(LD_PAGE);
  typedef enum logic [2:0] {IDLE, WAIT, OP, ARG0, ARG1, SEND, LOAD, ERR} state_t;
  state_t state, state_n, ret, ret_n;
  logic [AW-1:0] ptr, saved, ptr_inc, tgt;
  logic [AW-1:0] stack [2**SPW];
  logic [SPW-1:0] sp, sp_dec;
  logic [7:0] op, lo;
  logic [7:0] r [4];
  logic is_halt, is_br, is_ret, is_send, is_dec, is_inc, is_add, is_ld, is_bad;
  logic op_mov, op_call, op_jnz, sp_empty, sp_full;
  assign rom_addr = ptr;
  assign ptr_inc  = ptr + 1'b1;
  assign tgt      = AW'({rom_data, lo});
  assign sp_dec   = sp - 1'b1;
  assign sp_empty = sp == '0;
  assign sp_full  = sp == SP_FULL;
  // Decode of the byte being fetched in OP; later states use the latched opcode.
  assign is_halt = rom_data == 8'h00;
  assign is_br   = rom_data == 8'h01 || rom_data == 8'h02 || rom_data[7:2] == 6'b000001 || rom_data[7:2] == 6'b000100;
  assign is_ret  = rom_data == 8'h03;
  assign is_send = rom_data[7:2] == 6'b000010;
  assign is_dec  = rom_data[7:2] == 6'b000011;
  assign is_inc  = rom_data[7:2] == 6'b000110;
  assign is_add  = rom_data[7:4] == 4'b1000;
  assign is_ld   = rom_data[7:4] == 4'b1100;
  assign is_bad  = !(is_halt || is_br || is_ret || is_send || is_dec || is_inc || is_add || is_ld);
  assign op_mov  = op[7:2] == 6'b000001;
  assign op_call = op == 8'h02;
  assign op_jnz  = op[7:2] == 6'b000100;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ret      <= OP;
      ptr      <= START;
      saved    <= START;
      sp       <= '0;
      op       <= '0;
      lo       <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
      err_code <= '0;
      for (int i = 0; i < 4; i++) r[i] <= '0;
    end else begin
      state <= state_n;
      ret   <= ret_n;
      done  <= 1'b0;
      if (start) begin
        ptr      <= START;
        sp       <= '0;
        err_code <= '0;
        tx_valid <= 1'b0;
      end else begin
        case (state)
          OP: begin
            op  <= rom_data;
            ptr <= ptr_inc;
            if (is_halt) done <= 1'b1;
            if (is_ret && sp_empty) err_code <= 2'd3;
            if (is_ret && !sp_empty) begin
              ptr <= stack[sp_dec];
              sp  <= sp_dec;
            end
            if (is_send) begin
              tx_data  <= r[rom_data[1:0]];
              tx_valid <= 1'b1;
            end
            if (is_dec) r[rom_data[1:0]] <= r[rom_data[1:0]] - 8'd1;
            if (is_inc) r[rom_data[1:0]] <= r[rom_data[1:0]] + 8'd1;
            if (is_add) r[rom_data[3:2]] <= r[rom_data[3:2]] + r[rom_data[1:0]];
            // LD detours ptr into the data page and parks the return address in saved.
            if (is_ld) begin
              saved <= ptr_inc;
              ptr   <= {PAGE, r[rom_data[1:0]]};
            end
            if (is_bad) err_code <= 2'd1;
          end
          ARG0: begin
            ptr <= ptr_inc;
            if (op_mov) r[op[1:0]] <= rom_data;
            else lo <= rom_data;
          end
          ARG1: begin
            if (op_call && sp_full) err_code <= 2'd2;
            else ptr <= (op_jnz && r[op[1:0]] == 8'd0) ? ptr_inc : tgt;
            if (op_call && !sp_full) begin
              stack[sp] <= ptr_inc;
              sp        <= sp + 1'b1;
            end
          end
          SEND: if (tx_ready) tx_valid <= 1'b0;
          LOAD: begin
            r[op[3:2]] <= rom_data;
            ptr        <= saved;
          end
          default: ;
        endcase
      end
    end
  end
  // ret holds the state to enter once the single ROM-latency WAIT cycle is over.
  always_comb begin
    state_n = state;
    ret_n   = ret;
    case (state)
      WAIT: state_n = ret;
      OP: begin
        state_n = is_halt ? IDLE : is_send ? SEND : (is_bad || (is_ret && sp_empty)) ? ERR : WAIT;
        ret_n   = is_br ? ARG0 : is_ld ? LOAD : OP;
      end
      ARG0: begin
        state_n = WAIT;
        ret_n   = op_mov ? OP : ARG1;
      end
      ARG1: begin
        state_n = (op_call && sp_full) ? ERR : WAIT;
        ret_n   = OP;
      end
      SEND: begin
        state_n = tx_ready ? WAIT : SEND;
        ret_n   = OP;
      end
      LOAD: begin
        state_n = WAIT;
        ret_n   = OP;
      end
      default: ;
    endcase
    if (start) begin
      state_n = WAIT;
      ret_n   = OP;
    end
  end
  always_comb begin
    busy  = !(state == IDLE || state == ERR);
    error = state == ERR;
  end
endmodule

// File: tb/tb_rom_sequencer.sv
// tb_rom_sequencer: random and directed programs checked against an instruction-level interpreter of the ISA.
module tb_rom_sequencer;
  localparam int AW = 9;
  localparam int SD = 4;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, tx_ready = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [7:0] rom_data, tx_data;
  logic tx_valid, busy, done, error;
  logic [1:0] err_code;
  logic [7:0] rom [512];
  logic [7:0] exp_q[$], got_q[$];
  int mr[4];
  int checks = 0, errors = 0, code;
  string cur = "reset";

  rom_sequencer #(.AW(AW), .STACK_DEPTH(SD), .LD_PAGE(1), .START_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done),
    .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h", cur, tag, got, exp);
    end
  endtask

  // Executes the program in rom from address 0; fills exp_q, returns 0 on HALT, an error code, or -1 if it never ends.
  function automatic int model();
    int pc = 0, op, n, x, tgt, nxt;
    int stk[$];
    exp_q.delete();
    for (int s = 0; s < 400; s++) begin
      op = int'(rom[pc]);
      pc = (pc + 1) % 512;
      n = op % 4;
      x = (op / 4) % 4;
      if (op == 0) return 0;
      if (op == 1 || op == 2 || (op >= 16 && op <= 19)) begin
        tgt = (int'(rom[(pc + 1) % 512]) * 256 + int'(rom[pc])) % 512;
        nxt = (pc + 2) % 512;
        pc = nxt;
        if (op == 2) begin
          if (stk.size() == SD) return 2;
          stk.push_back(nxt);
        end
        if (op < 16 || mr[n] != 0) pc = tgt;
      end else if (op >= 4 && op <= 7) begin
        mr[n] = int'(rom[pc]);
        pc = (pc + 1) % 512;
      end else if (op == 3) begin
        if (stk.size() == 0) return 3;
        pc = stk.pop_back();
      end else if (op >= 8 && op <= 11) exp_q.push_back(8'(mr[n]));
      else if (op >= 12 && op <= 15) mr[n] = (mr[n] + 255) % 256;
      else if (op >= 24 && op <= 27) mr[n] = (mr[n] + 1) % 256;
      else if (op >= 128 && op <= 143) mr[x] = (mr[x] + mr[n]) % 256;
      else if (op >= 192 && op <= 207) mr[x] = int'(rom[256 + mr[n]]);
      else return 1;
    end
    return -1;
  endfunction

  task automatic fill();
    foreach (rom[i]) rom[i] = 8'($urandom);
  endtask

  task automatic gen();
    int a = 0, len, k, n;
    logic [7:0] b [3];
    fill();
    while (a < 48) begin
      k = $urandom_range(0, 15);
      n = $urandom_range(0, 3);
      b[0] = 8'(4 + n);
      b[1] = 8'($urandom_range(0, 51));
      b[2] = 8'($urandom) & 8'hFE;
      len = 3;
      case (k)
        1, 2:    begin b[0] = 8'(8 + n); len = 1; end
        3:       begin b[0] = 8'(12 + n); len = 1; end
        4:       begin b[0] = 8'(24 + n); len = 1; end
        5:       begin b[0] = 8'(128 + $urandom_range(0, 15)); len = 1; end
        6:       begin b[0] = 8'(192 + $urandom_range(0, 15)); len = 1; end
        7:       b[0] = 8'(16 + n);
        8:       b[0] = 8'h01;
        9:       b[0] = 8'h02;
        10:      begin b[0] = 8'h03; len = 1; end
        11:      begin b[0] = 8'($urandom_range(32, 127)); len = 1; end
        default: begin b[1] = 8'($urandom); len = 2; end
      endcase
      for (int j = 0; j < len; j++) rom[a + j] = b[j];
      a += len;
    end
    for (int j = 0; j < 4; j++) rom[a + j] = 8'h00;
  endtask

  task automatic prep_rand(output int c);
    int saved[4];
    c = -1;
    for (int t = 0; t < 50 && c < 0; t++) begin
      saved = mr;
      gen();
      c = model();
      if (c < 0) mr = saved;
    end
  endtask

  task automatic nest(input int d);
    fill();
    for (int k = 0; k < d; k++) begin
      rom[16 * k] = 8'h02;
      rom[16 * k + 1] = 8'(16 * (k + 1));
      rom[16 * k + 2] = 8'h00;
      rom[16 * k + 3] = (k == 0) ? 8'h00 : 8'h03;
    end
    rom[16 * d] = 8'h09;
    rom[16 * d + 1] = 8'h03;
  endtask

  task automatic run(input int stall, input int c);
    int cyc = 0, vcnt = 0;
    bit fin = 0, pv = 0, phs = 0, seen = 0;
    logic [7:0] pd = '0;
    got_q.delete();
    @(negedge clk);
    tx_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_valid", tx_valid, 0);
    check("start_busy", busy, 1);
    while (!fin && cyc < 5000) begin
      if (pv && !phs) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, pd);
      end
      if (done) begin
        fin = 1;
        seen = 1;
        check("busy_at_done", busy, 0);
      end
      if (error) fin = 1;
      vcnt = tx_valid ? vcnt + 1 : 0;
      tx_ready = (stall > 0) ? (vcnt > stall) : 1'($urandom);
      phs = tx_valid && tx_ready;
      if (phs) got_q.push_back(tx_data);
      pv = tx_valid;
      pd = tx_data;
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    tx_ready = 1'b0;
    check("terminated", fin, 1);
    check("nbytes", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) if (i < got_q.size()) check("byte", got_q[i], exp_q[i]);
    check("done_seen", seen, c == 0);
    check("error", error, c != 0);
    check("err_code", err_code, c < 0 ? 0 : c);
    @(negedge clk);
    check("done_pulse", done, 0);
  endtask

  initial begin
    fill();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("tx_valid", tx_valid, 0);
    check("tx_data", tx_data, 0);
    check("busy", busy, 0);
    check("done", done, 0);
    check("error", error, 0);
    check("err_code", err_code, 0);
    check("rom_addr", rom_addr, 0);
    reset = 1'b0;

    cur = "send_stall";
    fill();
    rom[0] = 8'h04; rom[1] = 8'h41; rom[2] = 8'h08; rom[3] = 8'h00;
    code = model();
    run(5, code);

    cur = "start_in_stall";
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !tx_valid; i++) @(negedge clk);
    check("valid_seen", tx_valid, 1);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("valid_drop", tx_valid, 0);
    check("restart_addr", rom_addr, 0);
    run(0, code);

    cur = "loop";
    fill();
    rom[0] = 8'h05; rom[1] = 8'h03; rom[2] = 8'h09; rom[3] = 8'h0D;
    rom[4] = 8'h11; rom[5] = 8'h02; rom[6] = 8'h00; rom[7] = 8'h00;
    code = model();
    check("model_loop", exp_q.size(), 3);
    run(0, code);

    cur = "nest_ok";
    nest(SD);
    code = model();
    run(0, code);

    cur = "nest_over";
    nest(SD + 1);
    code = model();
    run(0, code);

    cur = "ret_empty";
    fill();
    rom[0] = 8'h03;
    code = model();
    run(0, code);

    cur = "bad_op";
    fill();
    rom[0] = 8'h20;
    code = model();
    run(0, code);

    cur = "ld";
    fill();
    rom[0] = 8'h06; rom[1] = 8'h05; rom[2] = 8'hCE; rom[3] = 8'h0B; rom[4] = 8'h00;
    rom[9'h105] = 8'h5A;
    code = model();
    run(0, code);

    cur = "wrap";
    fill();
    rom[0] = 8'h04; rom[1] = 8'h02; rom[2] = 8'h00;
    code = model();
    run(0, code);
    rom[0] = 8'h10; rom[1] = 8'hFF; rom[2] = 8'h01; rom[3] = 8'h08; rom[4] = 8'h00;
    rom[9'h1FF] = 8'h0C;
    code = model();
    run(0, code);

    for (int p = 0; p < 30; p++) begin
      cur = $sformatf("rand%0d", p);
      prep_rand(code);
      run((p % 5 == 0) ? 2 : 0, code);
    end

    cur = "reset_start";
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("busy", busy, 0);
    check("tx_valid", tx_valid, 0);
    check("rom_addr", rom_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
